// File: rtl/kw_rr_arbiter_n.sv
// rtl/kw_rr_arbiter_n.sv - N-requester round-robin arbiter with registered one-entry output slot
//
// Shares one output channel between N valid/ready requesters. A rotating
// priority pointer picks at most one requester per cycle; its word is routed
// through a one-hot select into a registered output slot. With PACKET=1 the
// grant is held on one requester from its first beat until its last beat.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_valid/o_ready    per-requester handshake (o_ready at most one-hot)
//   i_data[N]          per-requester data word
//   i_last             per-requester end-of-packet flag (used when PACKET=1)
//   o_valid/i_ready    output slot handshake
//   o_data, o_last     captured word and its end-of-packet flag
//   o_grant_onehot     one-hot source of o_data (zero when o_valid=0)
//   o_grant_idx        binary source of o_data (zero when o_valid=0)

module kw_rr_arbiter_n #(
    parameter int N      = 4,
    parameter int WIDTH  = 16,
    parameter int PACKET = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_valid,
    output logic [N-1:0]         o_ready,
    input  logic [WIDTH-1:0]     i_data [N],
    input  logic [N-1:0]         i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_last,
    output logic [N-1:0]         o_grant_onehot,
    output logic [$clog2(N)-1:0] o_grant_idx
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } lock_state_t;

    lock_state_t     r_state;
    lock_state_t     w_state_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_lock_idx;
    logic [IW-1:0]   w_lock_idx_next;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_scan_idx;
    int              w_scan_sum;
    logic            w_has_win;
    logic            w_slot_free;
    logic            w_xfer;
    logic            w_win_last;
    logic [N-1:0]    w_onehot;
    logic [WIDTH-1:0] w_sel_data;

    // Winner: the locked requester only, or the first valid requester at or
    // after the pointer. The scan runs from the farthest offset down so the
    // nearest valid requester is the last (and therefore winning) assignment.
    always_comb begin
        w_win      = '0;
        w_has_win  = 1'b0;
        w_scan_sum = 0;
        w_scan_idx = '0;
        if (r_state == ST_LOCKED) begin
            w_win     = r_lock_idx;
            w_has_win = i_valid[r_lock_idx];
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                w_scan_sum = int'(r_ptr) + i;
                if (w_scan_sum >= N) begin
                    w_scan_sum = w_scan_sum - N;
                end
                w_scan_idx = IW'(w_scan_sum);
                if (i_valid[w_scan_idx]) begin
                    w_win     = w_scan_idx;
                    w_has_win = 1'b1;
                end
            end
        end
    end

    assign w_slot_free = !o_valid || i_ready;
    assign w_xfer      = w_slot_free && w_has_win && !i_rst;
    assign w_win_last  = (PACKET != 0) && i_last[w_win];
    assign w_onehot    = {{(N-1){1'b0}}, 1'b1} << w_win;
    assign o_ready     = w_xfer ? w_onehot : '0;

    // AND-OR one-hot select of the winning requester's word.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_onehot[k]) begin
                w_sel_data = w_sel_data | i_data[k];
            end
        end
    end

    // Packet lock: a non-last beat locks onto its requester, the last beat
    // releases it. A single-beat packet never enters LOCKED.
    always_comb begin
        w_state_next    = r_state;
        w_lock_idx_next = r_lock_idx;
        if ((PACKET != 0) && w_xfer) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (!w_win_last) begin
                        w_state_next    = ST_LOCKED;
                        w_lock_idx_next = w_win;
                    end
                end
                ST_LOCKED: begin
                    if (w_win_last) begin
                        w_state_next = ST_UNLOCKED;
                    end
                end
                default: w_state_next = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_UNLOCKED;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_idx <= w_lock_idx_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr          <= '0;
            o_valid        <= 1'b0;
            o_data         <= '0;
            o_last         <= 1'b0;
            o_grant_onehot <= '0;
            o_grant_idx    <= '0;
        end else if (w_slot_free) begin
            if (w_xfer) begin
                o_valid        <= 1'b1;
                o_data         <= w_sel_data;
                o_last         <= w_win_last;
                o_grant_onehot <= w_onehot;
                o_grant_idx    <= w_win;
                // In packet mode the pointer only moves past a finished packet.
                if ((PACKET == 0) || w_win_last) begin
                    r_ptr <= (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
                end
            end else begin
                // Slot drains with nothing to refill it; data/last keep their values.
                o_valid        <= 1'b0;
                o_grant_onehot <= '0;
                o_grant_idx    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_kw_rr_arbiter_n.sv
// tb/tb_kw_rr_arbiter_n.sv - randomized self-checking bench for kw_rr_arbiter_n (PACKET=0 and PACKET=1)

module tb_kw_rr_arbiter_n;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         rdy;
    logic [N-1:0] vld [2];
    logic [N-1:0] lst [2];
    logic [N-1:0] ordy [2];
    logic [W-1:0] din [2][N];
    logic [W-1:0] din0 [N];
    logic [W-1:0] din1 [N];
    logic         ov [2];
    logic         ol [2];
    logic [W-1:0] od [2];
    logic [N-1:0] og [2];
    logic [1:0]   oi [2];

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            din0[k] = din[0][k];
            din1[k] = din[1][k];
        end
    end

    kw_rr_arbiter_n #(.N(N), .WIDTH(W), .PACKET(0)) u_dut_beat (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(ordy[0]),
        .i_data(din0), .i_last(lst[0]), .o_valid(ov[0]), .i_ready(rdy),
        .o_data(od[0]), .o_last(ol[0]), .o_grant_onehot(og[0]), .o_grant_idx(oi[0])
    );

    kw_rr_arbiter_n #(.N(N), .WIDTH(W), .PACKET(1)) u_dut_pkt (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(ordy[1]),
        .i_data(din1), .i_last(lst[1]), .o_valid(ov[1]), .i_ready(rdy),
        .o_data(od[1]), .o_last(ol[1]), .o_grant_onehot(og[1]), .o_grant_idx(oi[1])
    );

    // Reference model: slot contents, priority pointer, locked requester (-1 = none).
    int           m_ptr [2];
    int           m_lock [2];
    int           m_gidx [2];
    bit           m_v [2];
    bit           m_l [2];
    logic [W-1:0] m_d [2];
    logic [N-1:0] held [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m]  = 0;
            m_lock[m] = -1;
            m_gidx[m] = 0;
            m_v[m]    = 1'b0;
            m_l[m]    = 1'b0;
            m_d[m]    = '0;
        end
    endtask

    // One cycle, entered and left on a falling edge.
    // kind 0: random requesters with valid density pv percent; kind 1: all valid, data A000+k.
    task automatic step(input bit r, input int kind, input int pv);
        int           win;
        bit           sf;
        bit           blast;
        logic [N-1:0] er;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d o_valid", m), 32'(ov[m]), 32'(m_v[m]));
            chk($sformatf("m%0d o_data", m), 32'(od[m]), 32'(m_d[m]));
            chk($sformatf("m%0d o_last", m), 32'(ol[m]), 32'(m_l[m]));
            chk($sformatf("m%0d o_grant_onehot", m), 32'(og[m]),
                m_v[m] ? (32'd1 << m_gidx[m]) : 32'd0);
            chk($sformatf("m%0d o_grant_idx", m), 32'(oi[m]), m_v[m] ? 32'(m_gidx[m]) : 32'd0);
        end
        rst = r;
        rdy = (kind == 1) ? 1'b1 : ($urandom_range(0, 99) < 70);
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < N; k++) begin
                if (!held[m][k]) begin
                    if (kind == 1) begin
                        vld[m][k] = 1'b1;
                        din[m][k] = 16'hA000 + W'(k);
                        lst[m][k] = 1'b0;
                    end else begin
                        vld[m][k] = ($urandom_range(0, 99) < pv);
                        din[m][k] = W'($urandom);
                        lst[m][k] = ($urandom_range(0, 99) < 40);
                    end
                end
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            sf  = !m_v[m] || rdy;
            win = -1;
            if (m_lock[m] >= 0) begin
                if (vld[m][m_lock[m]]) win = m_lock[m];
            end else begin
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (m_ptr[m] + i) % N;
                    if (win < 0 && vld[m][c]) win = c;
                end
            end
            er = (!r && sf && win >= 0) ? (N'(1) << win) : '0;
            chk($sformatf("m%0d o_ready", m), 32'(ordy[m]), 32'(er));
            held[m] = vld[m] & ~er;
            if (r) begin
                m_ptr[m]  = 0;
                m_lock[m] = -1;
                m_gidx[m] = 0;
                m_v[m]    = 1'b0;
                m_l[m]    = 1'b0;
                m_d[m]    = '0;
            end else if (sf) begin
                if (win >= 0) begin
                    blast     = (m == 1) ? lst[m][win] : 1'b0;
                    m_v[m]    = 1'b1;
                    m_d[m]    = din[m][win];
                    m_l[m]    = blast;
                    m_gidx[m] = win;
                    if (m == 0 || blast) m_ptr[m] = (win + 1) % N;
                    if (m == 1) begin
                        if (m_lock[m] < 0 && !blast) m_lock[m] = win;
                        else if (m_lock[m] >= 0 && blast) m_lock[m] = -1;
                    end
                end else begin
                    m_v[m]    = 1'b0;
                    m_gidx[m] = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b0;
        for (int m = 0; m < 2; m++) begin
            held[m] = '0;
            lst[m]  = '0;
            vld[m]  = '1;
            for (int k = 0; k < N; k++) din[m][k] = 16'hA000 + W'(k);
        end
        model_reset();
        repeat (2) @(negedge clk);

        repeat (2) step(1'b1, 1, 0);
        repeat (12) step(1'b0, 1, 0);
        repeat (1500) step(($urandom_range(0, 63) == 0), 0, 50);
        repeat (1000) step(($urandom_range(0, 63) == 0), 0, 90);
        repeat (800) step(($urandom_range(0, 63) == 0), 0, 25);
        step(1'b0, 0, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
